pwm_duty_ramp: RTL
==================

Name: pwm_duty_ramp

Overview:
- Upstream duty-cycle sequencer for the PWM generator; drives its duty input.
- Performs soft-start / soft-stop ramps: 0 up to a latched target, hold, then back down to 0.
- Duty changes only on a PWM period-boundary tick, so the PWM never sees a mid-period duty change.
- Used for LED fade and motor soft-start.

Parameters:
- N, 8, PWM counter width; duty is N+1 bits, legal range 0..2^N.
- HOLD_BITS, 16, width of the hold-period counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- period_tick  input  1  one-clk pulse per PWM period (from PWM timer/counter wrap).
- start  input  1  one-clk pulse; begins a ramp sequence when IDLE.
- stop  input  1  one-clk pulse; forces ramp-down from any non-IDLE state.
- target_duty  input  N+1  peak duty; sampled on accepted start.
- step  input  N+1  duty increment/decrement per tick; sampled on accepted start.
- hold_periods  input  HOLD_BITS  ticks to stay at peak; sampled on accepted start.
- duty  output  N+1  registered duty to the PWM.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-clk pulse when a sequence ends at duty 0.

Behaviour:
- Reset: duty=0, busy=0, done=0, state=IDLE, all latched operands=0.
- Reset mid-operation aborts immediately, with no ramp-down.
- States: IDLE, RAMP_UP, HOLD, RAMP_DOWN. busy is a registered decode of state != IDLE.
- IDLE, start=1, stop=0:
  - Latch tgt = min(target_duty, 2^N).
  - Latch stp = (step==0) ? 1 : step.
  - Latch hold_periods.
  - Next cycle: RAMP_UP. duty does not change yet.
- IDLE, start=1, stop=1: stop wins; remain IDLE.
- start while not IDLE: ignored.
- RAMP_UP, on period_tick:
  - duty <= min(duty+stp, tgt), computed in N+2 bits with no wrap.
  - When the new duty equals tgt: go to HOLD with hold_cnt=0.
  - If tgt==0: the first tick leaves duty 0 and enters HOLD.
- HOLD, on period_tick:
  - hold_cnt increments.
  - When hold_cnt reaches hold_periods-1: go to RAMP_DOWN.
  - hold_periods==0: go to RAMP_DOWN on the first tick in HOLD, giving a minimum of one tick at peak.
- RAMP_DOWN, on period_tick:
  - duty <= (duty > stp) ? duty-stp : 0, saturating at zero.
  - When the new duty is 0: go to IDLE and pulse done in the same clk edge (done high for exactly the one following cycle).
- Latency: duty updates on the clk edge that samples period_tick=1. No change between ticks.
- stop (any non-IDLE state):
  - Next cycle: RAMP_DOWN, continuing from the current duty.
  - stop coincident with period_tick: the tick is processed as RAMP_DOWN (the decrement applies on that edge).
  - stop in RAMP_DOWN: no effect.
- start, stop and period_tick are single-cycle pulses; levels held longer are treated as repeated pulses.
- done=0 in all other cycles. Duty is never outside 0..tgt.

Optional Feature:
- Macro: DUTY_RAMP_LOOP_EN.
- Defined (breathing mode):
  - When RAMP_DOWN reaches 0 and no stop has been accepted, done pulses and the state returns to RAMP_UP (not IDLE), reusing the latched operands.
  - busy stays high.
  - A sequence terminated by stop ends in IDLE with done.
- Undefined: every RAMP_DOWN reaching 0 ends in IDLE. The loop logic and its stop-request flag are not synthesized.

Test Plan:
- Basic ramp, N=8, target=200, step=50, hold=2, period_tick every 16 clks:
  - Duty per tick: 50,100,150,200,200,200,150,100,50,0.
  - done is one pulse after the final 0, then busy=0.
- Clamping, target=200, step=60:
  - Up: 60,120,180,200.
  - Down: 140,80,20,0.
  - Duty never exceeds 200 or underflows.
- Target over range and zero step, target=300, step=0, hold=0:
  - tgt latched as 256, step treated as 1.
  - Ramps to 256 in 256 ticks, holds 1 tick, then ramps down.
- stop mid-ramp at duty=100, step=50, with stop coincident with a tick: duty 50 on that edge, then 0, done, IDLE.
- Overlaps:
  - start while busy: ignored.
  - start+stop together in IDLE: stays IDLE, duty=0.
  - reset asserted at duty=150: duty=0, busy=0 asynchronously, with no done.
- With DUTY_RAMP_LOOP_EN (target=100, step=50, hold=1):
  - Duty repeats 50,100,100,50,0,50,...
  - done pulses at each 0.
  - stop then yields ramp to 0 and IDLE.

Source files
------------

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: soft-start/soft-stop duty sequencer that updates only on PWM period ticks.
// Optional breathing mode (ramp repeats until stopped) is enabled by defining DUTY_RAMP_LOOP_EN.
module pwm_duty_ramp #(
    parameter int N         = 8,
    parameter int HOLD_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 period_tick,
    input  logic                 start,
    input  logic                 stop,
    input  logic [N:0]           target_duty,
    input  logic [N:0]           step,
    input  logic [HOLD_BITS-1:0] hold_periods,
    output logic [N:0]           duty,
    output logic                 busy,
    output logic                 done
);
    localparam logic [N:0] DUTY_MAX = {1'b1, {N{1'b0}}};
    localparam logic [N:0] ONE = {{N{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RAMP_UP, HOLD, RAMP_DOWN} state_t;

    state_t               state, state_n;
    logic [N:0]           tgt, tgt_n, stp, stp_n, duty_n;
    logic [HOLD_BITS-1:0] hold, hold_n, cnt, cnt_n;
    logic                 done_n;
    logic [N+1:0]         sum;
    logic [N:0]           up, dn;
    logic                 loop_ok;

    // The up-step sum is one bit wider so a large step cannot wrap past tgt.
    assign sum = {1'b0, duty} + {1'b0, stp};
    assign up  = (sum > {1'b0, tgt}) ? tgt : sum[N:0];
    assign dn  = (duty > stp) ? duty - stp : '0;

`ifdef DUTY_RAMP_LOOP_EN
    logic stop_req, stop_req_n;
    assign loop_ok = !stop_req && !stop;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stop_req <= 1'b0;
        else       stop_req <= stop_req_n;
    end
`else
    assign loop_ok = 1'b0;
`endif

    always_comb begin
        state_n = state;
        duty_n  = duty;
        tgt_n   = tgt;
        stp_n   = stp;
        hold_n  = hold;
        cnt_n   = cnt;
        done_n  = 1'b0;
`ifdef DUTY_RAMP_LOOP_EN
        stop_req_n = stop_req;
`endif
        if (state == IDLE) begin
`ifdef DUTY_RAMP_LOOP_EN
            stop_req_n = 1'b0;
`endif
            if (start && !stop) begin
                state_n = RAMP_UP;
                tgt_n   = (target_duty > DUTY_MAX) ? DUTY_MAX : target_duty;
                stp_n   = (step == '0) ? ONE : step;
                hold_n  = hold_periods;
            end
        end else if (state == RAMP_DOWN || stop) begin
            // A stop takes effect on this edge, so a coincident tick already decrements.
            state_n = RAMP_DOWN;
`ifdef DUTY_RAMP_LOOP_EN
            if (stop) stop_req_n = 1'b1;
`endif
            if (period_tick) begin
                duty_n = dn;
                if (dn == '0) begin
                    done_n  = 1'b1;
                    state_n = loop_ok ? RAMP_UP : IDLE;
                end
            end
        end else if (period_tick) begin
            if (state == RAMP_UP) begin
                duty_n = up;
                if (up == tgt) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end
            end else if (hold == '0 || cnt == hold - HOLD_BITS'(1)) begin
                state_n = RAMP_DOWN;
            end else begin
                cnt_n = cnt + HOLD_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            duty  <= '0;
            tgt   <= '0;
            stp   <= '0;
            hold  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            duty  <= duty_n;
            tgt   <= tgt_n;
            stp   <= stp_n;
            hold  <= hold_n;
            cnt   <= cnt_n;
            busy  <= (state_n != IDLE);
            done  <= done_n;
        end
    end
endmodule
